coco_counter_arb: RTL and testbench



---
 rtl/coco_counter_arb.sv | 117 +++++++++++
 tb/tb_coco_counter_arb.sv | 232 +++++++++++++++++++++++
 2 files changed

// File: rtl/coco_counter_arb.sv
// Round-robin two-master sequencer for the coco_counter register port.
// Each grant runs IDLE -> ACC (device access) -> RSP (acknowledge); the IRQ follows the last CTRL writer.
module coco_counter_arb (
    input  logic        clk,
    input  logic        rst,
    input  logic        M0_REQ,
    input  logic        M0_WE,
    input  logic [3:2]  M0_ADD,
    input  logic [31:0] M0_WDAT,
    output logic        M0_ACK,
    output logic [31:0] M0_RDAT,
    output logic        M0_IRQ,
    input  logic        M1_REQ,
    input  logic        M1_WE,
    input  logic [3:2]  M1_ADD,
    input  logic [31:0] M1_WDAT,
    output logic        M1_ACK,
    output logic [31:0] M1_RDAT,
    output logic        M1_IRQ,
    output logic [3:2]  ADD_O,
    output logic        WE_O,
    output logic [31:0] DAT_O,
    input  logic [31:0] DAT_I,
    input  logic        IRQ_I
);

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_ACC  = 2'd1;
    localparam logic [1:0] ST_RSP  = 2'd2;

    logic [1:0] state;
    logic       gnt;
    logic       last;
    logic       owner;
    logic       req_any;
    logic       nxt_gnt;

    // On a tie the master that did not win last time is granted.
    always_comb begin
        req_any = M0_REQ | M1_REQ;
        nxt_gnt = M1_REQ;
        if (M0_REQ && M1_REQ) begin
            nxt_gnt = ~last;
        end
    end

    // Control: state, grant history, IRQ owner, write strobe and acknowledges
    always_ff @(posedge clk) begin
        if (rst) begin
            state  <= ST_IDLE;
            gnt    <= 1'b0;
            last   <= 1'b1;
            owner  <= 1'b0;
            WE_O   <= 1'b0;
            M0_ACK <= 1'b0;
            M1_ACK <= 1'b0;
        end else begin
            M0_ACK <= 1'b0;
            M1_ACK <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (req_any) begin
                        state <= ST_ACC;
                        gnt   <= nxt_gnt;
                        last  <= nxt_gnt;
                        WE_O  <= nxt_gnt ? M1_WE : M0_WE;
                    end
                end
                ST_ACC: begin
                    state <= ST_RSP;
                    WE_O  <= 1'b0;
                    if (gnt) begin
                        M1_ACK <= 1'b1;
                    end else begin
                        M0_ACK <= 1'b1;
                    end
                    if (WE_O && (ADD_O == 2'b00)) begin
                        owner <= gnt;
                    end
                end
                ST_RSP: begin
                    state <= ST_IDLE;
                end
                default: begin
                    state <= ST_IDLE;
                    WE_O  <= 1'b0;
                end
            endcase
        end
    end

    // Data: captured request fields drive the bus; read data lands at the end of ACC
    always_ff @(posedge clk) begin
        if (rst) begin
            ADD_O   <= 2'b00;
            DAT_O   <= 32'd0;
            M0_RDAT <= 32'd0;
            M1_RDAT <= 32'd0;
        end else begin
            if ((state == ST_IDLE) && req_any) begin
                ADD_O <= nxt_gnt ? M1_ADD  : M0_ADD;
                DAT_O <= nxt_gnt ? M1_WDAT : M0_WDAT;
            end
            if (state == ST_ACC) begin
                if (gnt) begin
                    M1_RDAT <= DAT_I;
                end else begin
                    M0_RDAT <= DAT_I;
                end
            end
        end
    end

    assign M0_IRQ = IRQ_I & ~owner;
    assign M1_IRQ = IRQ_I & owner;

endmodule

// File: tb/tb_coco_counter_arb.sv
// Bench for coco_counter_arb: a register-file stand-in for the counter plus a
// transaction-timestamp reference model checked every cycle.
module tb_coco_counter_arb;

    logic        clk;
    logic        rst;
    logic [1:0]  req;
    logic [1:0]  we;
    logic [1:0]  add [2];
    logic [31:0] wdat [2];
    logic        ack0, ack1, irq0, irq1;
    logic [31:0] rdat0, rdat1;
    logic [3:2]  add_o;
    logic        we_o;
    logic [31:0] dat_o;
    logic [31:0] dat_i;
    logic        irq_i;

    coco_counter_arb dut (
        .clk(clk), .rst(rst),
        .M0_REQ(req[0]), .M0_WE(we[0]), .M0_ADD(add[0]), .M0_WDAT(wdat[0]),
        .M0_ACK(ack0), .M0_RDAT(rdat0), .M0_IRQ(irq0),
        .M1_REQ(req[1]), .M1_WE(we[1]), .M1_ADD(add[1]), .M1_WDAT(wdat[1]),
        .M1_ACK(ack1), .M1_RDAT(rdat1), .M1_IRQ(irq1),
        .ADD_O(add_o), .WE_O(we_o), .DAT_O(dat_o), .DAT_I(dat_i), .IRQ_I(irq_i)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Counter stand-in: four plain registers, combinational read of ADD_O
    logic [31:0] dev [4];
    logic        dev_clr;
    always @(posedge clk) begin
        if (dev_clr) begin
            for (int i = 0; i < 4; i++) dev[i] <= 32'd0;
        end else if (we_o) begin
            dev[add_o] <= dat_o;
        end
    end
    assign dat_i = dev[add_o];

    int n_vec  = 0;
    int n_miss = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_miss++;
            $display("FAIL %s got=%0h exp=%0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // Reference model: a transaction granted at edge g owns the bus for edges g..g+2
    int          ecnt      = 0;
    int          free_edge = 0;
    int          g_edge    = -10;
    bit          txn_vld   = 0;
    bit          t_g;
    bit          t_we;
    logic [1:0]  t_add;
    logic [31:0] t_wdat;
    bit          m_last    = 1;
    bit          m_owner   = 0;
    logic [31:0] m_reg [4];
    logic [31:0] exp_rdat [2];
    logic [1:0]  exp_add   = 2'b00;
    logic [31:0] exp_dat   = 32'd0;

    task automatic step();
        bit g;
        bit acc_end;
        @(posedge clk);
        ecnt++;
        acc_end = txn_vld && (ecnt == g_edge + 1);
        if (rst) begin
            if (acc_end && t_we) m_reg[t_add] = t_wdat;
            txn_vld     = 0;
            free_edge   = ecnt + 1;
            m_last      = 1;
            m_owner     = 0;
            exp_rdat[0] = 32'd0;
            exp_rdat[1] = 32'd0;
            exp_add     = 2'b00;
            exp_dat     = 32'd0;
        end else begin
            if (acc_end) begin
                exp_rdat[t_g] = m_reg[t_add];
                if (t_we) begin
                    m_reg[t_add] = t_wdat;
                    if (t_add == 2'b00) m_owner = t_g;
                end
            end
            if (ecnt >= free_edge && (req[0] || req[1])) begin
                g         = (req[0] && req[1]) ? ~m_last : req[1];
                m_last    = g;
                t_g       = g;
                t_we      = we[g];
                t_add     = add[g];
                t_wdat    = wdat[g];
                exp_add   = add[g];
                exp_dat   = wdat[g];
                txn_vld   = 1;
                g_edge    = ecnt;
                free_edge = ecnt + 3;
            end
        end
        #1;
        chk("we_o",  we_o,  txn_vld && ecnt == g_edge && t_we);
        chk("add_o", add_o, exp_add);
        chk("dat_o", dat_o, exp_dat);
        chk("ack0",  ack0,  txn_vld && ecnt == g_edge + 1 && t_g == 0);
        chk("ack1",  ack1,  txn_vld && ecnt == g_edge + 1 && t_g == 1);
        chk("ack_onehot", ack0 & ack1, 0);
        chk("rdat0", rdat0, exp_rdat[0]);
        chk("rdat1", rdat1, exp_rdat[1]);
        chk("irq0",  irq0,  irq_i & (m_owner == 0));
        chk("irq1",  irq1,  irq_i & (m_owner == 1));
    endtask

    task automatic wait_ack(input int m);
        int n = 0;
        do begin
            step();
            n++;
        end while (!(m ? ack1 : ack0) && n < 8);
        chk(m ? "ack1_seen" : "ack0_seen", m ? ack1 : ack0, 1);
    endtask

    int wcnt [2];
    int n0, n1;

    initial begin
        rst = 1; dev_clr = 1; req = 2'b00; we = 2'b00; irq_i = 0;
        add[0] = 2'b00; add[1] = 2'b00; wdat[0] = 32'd0; wdat[1] = 32'd0;
        for (int i = 0; i < 4; i++) m_reg[i] = 32'd0;
        exp_rdat[0] = 32'd0; exp_rdat[1] = 32'd0;
        step(); step();
        rst = 0; dev_clr = 0;
        step();

        // M0 single write to register 2
        req[0] = 1; we[0] = 1; add[0] = 2'b10; wdat[0] = 32'h5;
        step();
        chk("t1_we", we_o, 1); chk("t1_add", add_o, 2'b10); chk("t1_dat", dat_o, 32'h5);
        chk("t1_ack_early", ack0, 0);
        step();
        chk("t1_ack", ack0, 1); chk("t1_we_drop", we_o, 0);
        req[0] = 0;
        step();
        chk("t1_ack_pulse", ack0, 0);

        // Simultaneous reads after reset, both held: strict alternation from M0
        rst = 1; step(); rst = 0;
        req = 2'b11; we = 2'b00; add[0] = 2'b10; add[1] = 2'b00;
        n0 = 0; n1 = 0;
        for (int i = 0; i < 11; i++) begin
            step();
            if (i == 1) begin
                chk("t2_first_m0", ack0, 1);
                chk("t2_rdat0", rdat0, 32'h5);
            end
            if (ack0) n0++;
            if (ack1) n1++;
        end
        chk("t2_n_ack0", n0, 2); chk("t2_n_ack1", n1, 2);
        req = 2'b00;
        step(); step();

        // IRQ steering follows the last CTRL writer
        req[1] = 1; we[1] = 1; add[1] = 2'b00; wdat[1] = 32'hB;
        step(); step();
        chk("t3_ack1", ack1, 1);
        req[1] = 0; irq_i = 1;
        step();
        chk("t3_m1_irq", irq1, 1); chk("t3_m0_irq", irq0, 0);
        req[0] = 1; we[0] = 1; add[0] = 2'b00; wdat[0] = 32'h9;
        step(); step();
        chk("t3_ack0", ack0, 1);
        req[0] = 0;
        step();
        chk("t3b_m0_irq", irq0, 1); chk("t3b_m1_irq", irq1, 0);
        irq_i = 0;

        // Reset in the ACC cycle of an M1 write
        req[1] = 1; we[1] = 1; add[1] = 2'b01; wdat[1] = 32'h77;
        step();
        chk("t5_we", we_o, 1);
        rst = 1; req[1] = 0;
        step();
        chk("t5_no_ack1", ack1, 0); chk("t5_we0", we_o, 0);
        chk("t5_add0", add_o, 0); chk("t5_dat0", dat_o, 0);
        chk("t5_rdat0", rdat0, 0); chk("t5_rdat1", rdat1, 0);
        rst = 0;
        req = 2'b11; we = 2'b00; add[0] = 2'b01; add[1] = 2'b11;
        step();
        chk("t5_tie_m0", add_o, 2'b01);
        step();
        chk("t5_ack0", ack0, 1); chk("t5_kept_write", rdat0, 32'h77);
        req[0] = 0;
        wait_ack(1);
        req[1] = 0;
        step();

        // Random traffic on both masters
        wcnt[0] = 0; wcnt[1] = 0;
        for (int c = 0; c < 1000; c++) begin
            step();
            for (int m = 0; m < 2; m++) begin
                bit a;
                a = m ? ack1 : ack0;
                if (req[m]) wcnt[m]++;
                if (a) begin
                    chk("wait_bound", wcnt[m] <= 6, 1);
                    wcnt[m] = 0;
                    if ($urandom_range(3) != 0) req[m] = 0;
                end else if (!req[m] && $urandom_range(2) == 0) begin
                    req[m]  = 1;
                    we[m]   = 1'($urandom_range(1));
                    add[m]  = 2'($urandom_range(3));
                    wdat[m] = $urandom;
                    wcnt[m] = 0;
                end
            end
            irq_i = 1'($urandom_range(1));
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
